// File: rtl/integral_pkg.sv
// rtl/integral_pkg.sv - shared types and default geometry for the integral-image chain
// Purpose: FSM state encoding for the rectangle-sum consumer and the default
//          window geometry shared with the row stages.
// Ports:   none (package).
package integral_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_IWIDTH      = 3;
    localparam int DEF_IHEIGHT     = 3;
    localparam int DEF_COORD_WIDTH = 4;

endpackage

// File: rtl/integral_corner_fetch.sv
// rtl/integral_corner_fetch.sv - combinational select of one integral corner from the window
// Purpose: returns I(row, col) from the flattened snapshot. Indices arrive in
//          "plus one" form so that a value of 0 encodes index -1, which reads as 0.
//          Out-of-window indices also read as 0; such descriptors are flagged as
//          errors upstream and their value is discarded.
// Ports:
//   i_window  - flattened snapshot, entry (r,c) at [(r*IWIDTH+c)*DATA_WIDTH +: DATA_WIDTH]
//   i_row_p1  - row index + 1
//   i_col_p1  - column index + 1
//   o_value   - selected integral value
module integral_corner_fetch
    import integral_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IWIDTH      = DEF_IWIDTH,
    parameter int IHEIGHT     = DEF_IHEIGHT,
    parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
    input  logic [IHEIGHT*IWIDTH*DATA_WIDTH-1:0] i_window,
    input  logic [COORD_WIDTH:0]                 i_row_p1,
    input  logic [COORD_WIDTH:0]                 i_col_p1,
    output logic [DATA_WIDTH-1:0]                o_value
);

    localparam int CW1 = COORD_WIDTH + 1;

    always_comb begin
        o_value = '0;
        for (int r = 0; r < IHEIGHT; r++) begin
            for (int c = 0; c < IWIDTH; c++) begin
                if (i_row_p1 == CW1'(r + 1) && i_col_p1 == CW1'(c + 1)) begin
                    o_value = i_window[(r*IWIDTH+c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/integral_rect_sum.sv
// rtl/integral_rect_sum.sv - snapshot an integral window and return Haar rectangle sums
// Purpose: latches one IHEIGHT x IWIDTH integral window, then evaluates a stream of
//          rectangle descriptors through a two-stage pipe (corner fetch, then
//          four-term add/subtract), modulo 2^DATA_WIDTH.
// Ports:
//   clk_os, reset_os             - clock, asynchronous active-low reset
//   i_window_valid/o_window_ready - window handshake, i_window_data flattened window
//   i_rect_*/o_rect_ready        - descriptor stream (x, y, w, h, last)
//   o_sum_*/i_sum_ready          - result stream (sum, err, last)
module integral_rect_sum
    import integral_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IWIDTH      = DEF_IWIDTH,
    parameter int IHEIGHT     = DEF_IHEIGHT,
    parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
    input  logic                                 clk_os,
    input  logic                                 reset_os,
    input  logic                                 i_window_valid,
    input  logic [IHEIGHT*IWIDTH*DATA_WIDTH-1:0] i_window_data,
    output logic                                 o_window_ready,
    input  logic                                 i_rect_valid,
    input  logic [COORD_WIDTH-1:0]               i_rect_x,
    input  logic [COORD_WIDTH-1:0]               i_rect_y,
    input  logic [COORD_WIDTH-1:0]               i_rect_w,
    input  logic [COORD_WIDTH-1:0]               i_rect_h,
    input  logic                                 i_rect_last,
    output logic                                 o_rect_ready,
    output logic                                 o_sum_valid,
    output logic [DATA_WIDTH-1:0]                o_sum,
    output logic                                 o_sum_err,
    output logic                                 o_sum_last,
    input  logic                                 i_sum_ready
);

    localparam int CW1   = COORD_WIDTH + 1;
    localparam int WIN_W = IHEIGHT * IWIDTH * DATA_WIDTH;

    state_t                r_state;
    state_t                w_next_state;
    logic [WIN_W-1:0]      r_window;
    logic                  r_window_ready;

    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic                  r_s1_last;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic [DATA_WIDTH-1:0] r_s1_c;
    logic [DATA_WIDTH-1:0] r_s1_d;

    logic                  r_sum_valid;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_sum_err;
    logic                  r_sum_last;

    logic                  w_advance;
    logic                  w_rect_ready;
    logic                  w_rect_fire;
    logic                  w_window_fire;
    logic                  w_sum_fire;
    logic [CW1-1:0]        w_x_p1;
    logic [CW1-1:0]        w_y_p1;
    logic [CW1-1:0]        w_x_end;
    logic [CW1-1:0]        w_y_end;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_c;
    logic [DATA_WIDTH-1:0] w_d;

    assign w_advance     = !r_sum_valid || i_sum_ready;
    assign w_rect_ready  = (r_state == EVAL) && w_advance;
    assign w_rect_fire   = i_rect_valid && w_rect_ready;
    assign w_window_fire = i_window_valid && r_window_ready && (r_state == IDLE);
    assign w_sum_fire    = r_sum_valid && i_sum_ready;

    // Corner indices are carried as index+1: origin x/y directly encodes x-1/y-1,
    // and x+w / y+h encodes the inclusive far edge. Sums are done in COORD_WIDTH+1
    // bits so a far edge can never wrap back into the window.
    assign w_x_p1  = {1'b0, i_rect_x};
    assign w_y_p1  = {1'b0, i_rect_y};
    assign w_x_end = {1'b0, i_rect_x} + {1'b0, i_rect_w};
    assign w_y_end = {1'b0, i_rect_y} + {1'b0, i_rect_h};

    assign w_err = (i_rect_w == '0) || (i_rect_h == '0) ||
                   (w_x_end > CW1'(IWIDTH)) || (w_y_end > CW1'(IHEIGHT));

    integral_corner_fetch #(
        .DATA_WIDTH(DATA_WIDTH), .IWIDTH(IWIDTH), .IHEIGHT(IHEIGHT), .COORD_WIDTH(COORD_WIDTH)
    ) u_fetch_a (
        .i_window(r_window), .i_row_p1(w_y_end), .i_col_p1(w_x_end), .o_value(w_a)
    );

    integral_corner_fetch #(
        .DATA_WIDTH(DATA_WIDTH), .IWIDTH(IWIDTH), .IHEIGHT(IHEIGHT), .COORD_WIDTH(COORD_WIDTH)
    ) u_fetch_b (
        .i_window(r_window), .i_row_p1(w_y_p1), .i_col_p1(w_x_end), .o_value(w_b)
    );

    integral_corner_fetch #(
        .DATA_WIDTH(DATA_WIDTH), .IWIDTH(IWIDTH), .IHEIGHT(IHEIGHT), .COORD_WIDTH(COORD_WIDTH)
    ) u_fetch_c (
        .i_window(r_window), .i_row_p1(w_y_end), .i_col_p1(w_x_p1), .o_value(w_c)
    );

    integral_corner_fetch #(
        .DATA_WIDTH(DATA_WIDTH), .IWIDTH(IWIDTH), .IHEIGHT(IHEIGHT), .COORD_WIDTH(COORD_WIDTH)
    ) u_fetch_d (
        .i_window(r_window), .i_row_p1(w_y_p1), .i_col_p1(w_x_p1), .o_value(w_d)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_window_fire) w_next_state = EVAL;
            EVAL:  if (w_rect_fire && i_rect_last) w_next_state = DRAIN;
            // The last result is always the youngest, so stage 1 is empty by the
            // time it handshakes; the check keeps the exit condition explicit.
            DRAIN: if (w_sum_fire && r_sum_last && !r_s1_valid) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            r_state        <= IDLE;
            r_window_ready <= 1'b0;
            r_window       <= '0;
        end else begin
            r_state        <= w_next_state;
            r_window_ready <= (w_next_state == IDLE);
            if (w_window_fire) begin
                r_window <= i_window_data;
            end
        end
    end

    // Stage 1: corner fetch and error flag.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_d     <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_rect_fire;
            if (w_rect_fire) begin
                r_s1_err  <= w_err;
                r_s1_last <= i_rect_last;
                r_s1_a    <= w_a;
                r_s1_b    <= w_b;
                r_s1_c    <= w_c;
                r_s1_d    <= w_d;
            end
        end
    end

    // Stage 2: four-term sum. Data only loads with a valid stage-1 entry so the
    // outputs keep their last value while the pipe drains.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            r_sum_valid <= 1'b0;
            r_sum       <= '0;
            r_sum_err   <= 1'b0;
            r_sum_last  <= 1'b0;
        end else if (w_advance) begin
            r_sum_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum      <= r_s1_err ? '0 : (r_s1_a - r_s1_b - r_s1_c + r_s1_d);
                r_sum_err  <= r_s1_err;
                r_sum_last <= r_s1_last;
            end
        end
    end

    assign o_window_ready = r_window_ready;
    assign o_rect_ready   = w_rect_ready;
    assign o_sum_valid    = r_sum_valid;
    assign o_sum          = r_sum;
    assign o_sum_err      = r_sum_err;
    assign o_sum_last     = r_sum_last;

endmodule

// File: tb/tb_integral_rect_sum.sv
// tb/tb_integral_rect_sum.sv - scoreboard bench for integral_rect_sum
module tb_integral_rect_sum;

    localparam int DW = 8;
    localparam int IW = 3;
    localparam int IH = 3;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] sum;
        logic          err;
        logic          last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_window_valid = 1'b0;
    logic [IH*IW*DW-1:0] i_window_data = '0;
    logic                o_window_ready;
    logic                i_rect_valid = 1'b0;
    logic [CW-1:0]       i_rect_x = '0;
    logic [CW-1:0]       i_rect_y = '0;
    logic [CW-1:0]       i_rect_w = '0;
    logic [CW-1:0]       i_rect_h = '0;
    logic                i_rect_last = 1'b0;
    logic                o_rect_ready;
    logic                o_sum_valid;
    logic [DW-1:0]       o_sum;
    logic                o_sum_err;
    logic                o_sum_last;
    logic                i_sum_ready = 1'b1;

    integral_rect_sum #(
        .DATA_WIDTH(DW), .IWIDTH(IW), .IHEIGHT(IH), .COORD_WIDTH(CW)
    ) dut (
        .clk_os(clk), .reset_os(rst_n),
        .i_window_valid(i_window_valid), .i_window_data(i_window_data),
        .o_window_ready(o_window_ready),
        .i_rect_valid(i_rect_valid), .i_rect_x(i_rect_x), .i_rect_y(i_rect_y),
        .i_rect_w(i_rect_w), .i_rect_h(i_rect_h), .i_rect_last(i_rect_last),
        .o_rect_ready(o_rect_ready),
        .o_sum_valid(o_sum_valid), .o_sum(o_sum), .o_sum_err(o_sum_err),
        .o_sum_last(o_sum_last), .i_sum_ready(i_sum_ready)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   pix[IH][IW];
    int   cur_pix[IH][IW];
    int   stall_cnt = 0;
    bit   rand_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a rectangle sum is the plain sum of its pixels.
    function automatic exp_t model(int x, int y, int w, int h, bit last);
        exp_t e;
        int   s = 0;
        e.last = last;
        if (w == 0 || h == 0 || x + w > IW || y + h > IH) begin
            e.err = 1'b1;
            e.sum = '0;
        end else begin
            for (int r = y; r < y + h; r++)
                for (int c = x; c < x + w; c++)
                    s += cur_pix[r][c];
            e.err = 1'b0;
            e.sum = DW'(s % 256);
        end
        return e;
    endfunction

    function automatic logic [IH*IW*DW-1:0] build(input int p[IH][IW]);
        logic [IH*IW*DW-1:0] d = '0;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                int s = 0;
                for (int i = 0; i <= r; i++)
                    for (int j = 0; j <= c; j++)
                        s += p[i][j];
                d[(r*IW+c)*DW +: DW] = DW'(s % 256);
            end
        return d;
    endfunction

    task automatic fill(input int v);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                pix[r][c] = (v < 0) ? int'($urandom_range(0, 255)) : v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            i_sum_ready = 1'b0;
            stall_cnt--;
        end else if (rand_stall) begin
            i_sum_ready = ($urandom_range(0, 3) != 0);
        end else begin
            i_sum_ready = 1'b1;
        end
    endtask

    task automatic load_window();
        bit hs = 0;
        int t = 0;
        i_window_data  = build(pix);
        i_window_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = o_window_ready;
            tick();
            t++;
        end while (!hs && t < 200);
        i_window_valid = 1'b0;
        if (!hs) chk("window_timeout", 0, 1);
        cur_pix = pix;
    endtask

    task automatic send_rect(input int x, input int y, input int w, input int h, input bit last);
        bit hs = 0;
        int t = 0;
        i_rect_x = CW'(x); i_rect_y = CW'(y);
        i_rect_w = CW'(w); i_rect_h = CW'(h);
        i_rect_last  = last;
        i_rect_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = o_rect_ready;
            tick();
            t++;
        end while (!hs && t < 200);
        i_rect_valid = 1'b0;
        if (hs) sb.push_back(model(x, y, w, h, last));
        else chk("rect_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit seen = 0;
        int t = 0;
        do begin
            @(negedge clk);
            seen = o_window_ready;
            if (!seen) tick();
            t++;
        end while (!seen && t < 300);
        chk("return_to_idle", seen, 1);
        chk("drain_sb_empty", sb.size(), 0);
        tick();
    endtask

    // Monitor: pops the scoreboard on every result handshake, checks hold during stalls.
    bit   prev_stall = 0;
    exp_t held;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", o_sum_valid, 1);
                chk("stall_sum", o_sum, held.sum);
                chk("stall_err", o_sum_err, held.err);
                chk("stall_last", o_sum_last, held.last);
            end
            if (o_sum_valid) begin
                if (i_sum_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", o_sum_valid, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sum", o_sum, e.sum);
                        chk("err", o_sum_err, e.err);
                        chk("last", o_sum_last, e.last);
                    end
                end
                held.sum  = o_sum;
                held.err  = o_sum_err;
                held.last = o_sum_last;
                prev_stall = !i_sum_ready;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        int n;
        int alt[IH][IW];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_window_ready", o_window_ready, 0);
        chk("rst_rect_ready", o_rect_ready, 0);
        chk("rst_sum_valid", o_sum_valid, 0);
        chk("rst_sum", o_sum, 0);
        chk("rst_sum_err", o_sum_err, 0);
        chk("rst_sum_last", o_sum_last, 0);
        rst_n = 1'b1;
        #1;
        chk("window_ready_at_release", o_window_ready, 0);
        tick();
        chk("window_ready_after_release", o_window_ready, 1);

        // All-ones window: latency and full rect with last
        fill(1);
        load_window();
        chk("rect_ready_after_load", o_rect_ready, 1);
        send_rect(1, 1, 2, 2, 0);
        chk("latency_cycle1_valid", o_sum_valid, 0);
        tick();
        chk("latency_cycle2_valid", o_sum_valid, 1);
        chk("latency_cycle2_sum", o_sum, 4);
        send_rect(0, 0, 3, 3, 1);
        wait_idle();

        // Pixels all 40: modular wrap
        fill(40);
        load_window();
        send_rect(0, 0, 3, 3, 0);
        send_rect(1, 1, 2, 2, 1);
        wait_idle();

        // Error descriptors followed by a valid one
        fill(1);
        load_window();
        send_rect(0, 0, 0, 1, 0);
        send_rect(2, 0, 2, 1, 0);
        send_rect(0, 0, 1, 1, 1);
        wait_idle();

        // Back-to-back stream with a 3-cycle stall mid-stream
        fill(-1);
        load_window();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) stall_cnt = 3;
            send_rect($urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(1, 3), $urandom_range(1, 3), k == 5);
        end
        wait_idle();

        // Reset with two results in flight
        fill(-1);
        load_window();
        send_rect(0, 0, 2, 2, 0);
        send_rect(1, 0, 2, 3, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sum_valid", o_sum_valid, 0);
        chk("midrst_rect_ready", o_rect_ready, 0);
        chk("midrst_window_ready", o_window_ready, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("postrst_window_ready", o_window_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("postrst_no_stale", o_sum_valid, 0);
            tick();
        end

        // Window pulse during EVAL must not disturb the snapshot
        fill(-1);
        load_window();
        send_rect(0, 0, 3, 3, 0);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                alt[r][c] = (cur_pix[r][c] + 77) % 256;
        i_window_data  = build(alt);
        i_window_valid = 1'b1;
        tick();
        tick();
        i_window_valid = 1'b0;
        send_rect(0, 0, 3, 3, 0);
        send_rect(1, 1, 2, 1, 1);
        wait_idle();

        // Randomised windows, descriptors and back-pressure
        rand_stall = 1;
        for (int wdx = 0; wdx < 20; wdx++) begin
            fill(-1);
            load_window();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send_rect(($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
                          $urandom_range(0, 3),
                          $urandom_range(0, 4),
                          ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
                          k == n - 1);
            end
            wait_idle();
        end
        rand_stall = 0;

        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
